// File: rtl/spi_req_arbiter_if.sv
// Bundles the client request/response signals and the spi_master-facing
// serial pins of spi_req_arbiter into one port.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      done;
    logic [DATA_W-1:0]         rx_data;
    logic [2:0]                rx_id;
    logic                      m_cs_in;
    logic                      m_data_in;
    logic [DATA_W-1:0]         m_dout;

    modport slave (
        input  req, req_data, m_dout,
        output gnt, busy, done, rx_data, rx_id, m_cs_in, m_data_in
    );

    modport master (
        output req, req_data, m_dout,
        input  gnt, busy, done, rx_data, rx_id, m_cs_in, m_data_in
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Shares one spi_master between NUM_REQ byte-wide requesters (round-robin).
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead.
module spi_req_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_req_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CYC_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  sel_data;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               any_req;
    logic [PTR_W-1:0]   winner;
    logic               bit_last;
    logic               shift_last;
    logic               gap_last;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               cs_nxt;
    logic               data_nxt;
    logic               done_nxt;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                any_req = 1'b1;
                winner  = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;

    // Scan downward from the farthest offset so the nearest set bit at or
    // after rr_ptr is the one left in winner.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        winner  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req[idx]) begin
                any_req = 1'b1;
                winner  = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (state == IDLE && any_req)
            rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
`endif

    assign sel_data   = bus.req_data[winner*DATA_W +: DATA_W];
    assign bit_last   = (cyc_cnt == CYC_W'(CLKS_PER_BIT - 1));
    assign shift_last = bit_last && (bit_cnt == BIT_W'(DATA_W - 1));
    assign gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign bus.busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SHIFT;
            SHIFT:   if (shift_last) state_nxt = CAPTURE;
            CAPTURE: state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; the serial pins are registered so
    // cs/data change on the same edge as gnt and each bit boundary.
    always_comb begin
        gnt_nxt  = '0;
        cs_nxt   = 1'b1;
        data_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_nxt[winner] = 1'b1;
                    cs_nxt          = 1'b0;
                    data_nxt        = sel_data[DATA_W-1];
                end
            end
            SHIFT: begin
                if (!shift_last) begin
                    cs_nxt   = 1'b0;
                    data_nxt = bit_last ? shift_reg[DATA_W-2] : shift_reg[DATA_W-1];
                end
            end
            CAPTURE: done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.gnt       <= '0;
            bus.m_cs_in   <= 1'b1;
            bus.m_data_in <= 1'b0;
            bus.done      <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_id     <= '0;
            shift_reg     <= '0;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
        end else begin
            bus.gnt       <= gnt_nxt;
            bus.m_cs_in   <= cs_nxt;
            bus.m_data_in <= data_nxt;
            bus.done      <= done_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shift_reg <= sel_data;
                        bus.rx_id <= 3'(winner);
                        cyc_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_last) begin
                        cyc_cnt   <= '0;
                        bit_cnt   <= bit_cnt + 1'b1;
                        shift_reg <= shift_reg << 1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    bus.rx_data <= bus.m_dout;
                    gap_cnt     <= '0;
                end
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a loopback spi_master model.
// Expected grant orders switch on SPI_ARB_FIXED_PRIO_EN.
module tb_spi_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         cycle        = 0;
    int         gnt_id_q[$];
    int         gnt_cyc_q[$];
    int         done_id_q[$];
    int         done_data_q[$];
    logic [7:0] lb_shift = 8'h00;
    int         lb_cnt   = 0;

`ifdef SPI_ARB_FIXED_PRIO_EN
    int exp_t2[5] = '{0, 0, 0, 0, 0};
    int exp_t2d[5] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    int exp_t3[5] = '{3, 3, 3, 0, 0};
    int exp_t6[3] = '{1, 1, 1};
`else
    int exp_t2[5] = '{0, 1, 2, 3, 0};
    int exp_t2d[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int exp_t3[5] = '{3, 3, 3, 0, 3};
    int exp_t6[3] = '{1, 3, 1};
`endif

    spi_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    spi_req_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CLKS_PER_BIT(2), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.m_dout = lb_shift;

    // Loopback master: samples the first cycle of every serial bit.
    always @(negedge clk) begin
        if (bus.m_cs_in) begin
            lb_cnt = 0;
        end else begin
            if (lb_cnt % 2 == 0) lb_shift = {lb_shift[6:0], bus.m_data_in};
            lb_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        #1;
        if (bus.gnt != '0) begin
            checkOutput("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
            checkOutput("gnt_in_shift", 32'({bus.busy, bus.m_cs_in}), 32'd2);
            for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) gnt_id_q.push_back(i);
            gnt_cyc_q.push_back(cycle);
        end
        if (bus.done) begin
            done_id_q.push_back(int'(bus.rx_id));
            done_data_q.push_back(int'(bus.rx_data));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        bus.req      = r;
        bus.req_data = d;
    endtask

    task automatic clearLogs();
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        done_id_q.delete();
        done_data_q.delete();
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    task automatic waitGrants(input int n, input int limit);
        int k;
        k = 0;
        while (gnt_id_q.size() < n && k < limit) begin
            tick(1);
            k++;
        end
        checkOutput("grant_wait", 32'(gnt_id_q.size() >= n), 32'd1);
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        logic [7:0] exp_byte;
        exp_byte = 8'hA5;
        applyStimulus(4'b0000, 32'h0);
        reset_n = 1'b0;
        tick(2);
        checkOutput("rst_cs", 32'(bus.m_cs_in), 32'd1);
        checkOutput("rst_data", 32'(bus.m_data_in), 32'd0);
        checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
        checkOutput("rst_rx_id", 32'(bus.rx_id), 32'd0);

        // Single transfer from requester 2, cycle-exact.
        reset_n = 1'b1;
        applyStimulus(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
        tick(1);
        checkOutput("t1_gnt", 32'(bus.gnt), 32'h4);
        checkOutput("t1_busy", 32'(bus.busy), 32'd1);
        applyStimulus(4'b0000, 32'h0);
        for (int k = 0; k < 16; k++) begin
            checkOutput("t1_cs_low", 32'(bus.m_cs_in), 32'd0);
            checkOutput("t1_bit", 32'(bus.m_data_in), 32'(exp_byte[7 - k/2]));
            tick(1);
        end
        checkOutput("t1_cs_high", 32'(bus.m_cs_in), 32'd1);
        checkOutput("t1_no_early_done", 32'(bus.done), 32'd0);
        tick(1);
        checkOutput("t1_done", 32'(bus.done), 32'd1);
        checkOutput("t1_rx_id", 32'(bus.rx_id), 32'd2);
        checkOutput("t1_rx_data", 32'(bus.rx_data), 32'hA5);
        tick(1);
        checkOutput("t1_done_pulse", 32'(bus.done), 32'd0);
        checkOutput("t1_gap_busy", 32'(bus.busy), 32'd1);
        tick(1);
        checkOutput("t1_idle", 32'(bus.busy), 32'd0);

        // All requesters held.
        pulseReset();
        clearLogs();
        applyStimulus(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        waitGrants(5, 200);
        applyStimulus(4'b0000, 32'h0);
        tick(25);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_order", 32'(at(gnt_id_q, i)), 32'(exp_t2[i]));
            checkOutput("t2_rx_id", 32'(at(done_id_q, i)), 32'(exp_t2[i]));
            checkOutput("t2_rx_data", 32'(at(done_data_q, i)), 32'(exp_t2d[i]));
        end
        for (int i = 1; i < 5; i++)
            checkOutput("t2_spacing", 32'(at(gnt_cyc_q, i) - at(gnt_cyc_q, i - 1)), 32'd20);

        // Requester 3 alone, then requester 0 joins.
        pulseReset();
        clearLogs();
        applyStimulus(4'b1000, {8'h5A, 24'h0});
        waitGrants(3, 100);
        applyStimulus(4'b1001, {8'h5A, 16'h0, 8'hC3});
        waitGrants(5, 100);
        applyStimulus(4'b0000, 32'h0);
        tick(25);
        for (int i = 0; i < 5; i++)
            checkOutput("t3_order", 32'(at(gnt_id_q, i)), 32'(exp_t3[i]));
        checkOutput("t3_b2b", 32'(at(gnt_cyc_q, 2) - at(gnt_cyc_q, 1)), 32'd20);

        // Short req[1] pulse while busy must never be granted.
        clearLogs();
        applyStimulus(4'b0001, {24'h0, 8'h3C});
        tick(1);
        applyStimulus(4'b0000, 32'h0);
        tick(5);
        applyStimulus(4'b0010, 32'h0);
        tick(1);
        applyStimulus(4'b0000, 32'h0);
        tick(40);
        checkOutput("t5_gnt_count", 32'(gnt_id_q.size()), 32'd1);
        checkOutput("t5_gnt_id", 32'(at(gnt_id_q, 0)), 32'd0);
        checkOutput("t5_rx_data", 32'(at(done_data_q, 0)), 32'h3C);

        // Reset during the fifth bit aborts the transfer.
        pulseReset();
        clearLogs();
        applyStimulus(4'b0001, {24'h0, 8'h96});
        tick(1);
        checkOutput("t4_gnt", 32'(bus.gnt), 32'h1);
        applyStimulus(4'b0000, 32'h0);
        tick(8);
        checkOutput("t4_mid_cs", 32'(bus.m_cs_in), 32'd0);
        reset_n = 1'b0;
        tick(1);
        checkOutput("t4_abort_cs", 32'(bus.m_cs_in), 32'd1);
        checkOutput("t4_abort_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        applyStimulus(4'b0011, {16'h0, 8'h77, 8'h69});
        tick(1);
        checkOutput("t4_regnt", 32'(bus.gnt), 32'h1);
        applyStimulus(4'b0000, 32'h0);
        tick(30);
        checkOutput("t4_gnt_count", 32'(gnt_id_q.size()), 32'd2);
        checkOutput("t4_done_count", 32'(done_id_q.size()), 32'd1);
        checkOutput("t4_rx_id", 32'(at(done_id_q, 0)), 32'd0);
        checkOutput("t4_rx_data", 32'(at(done_data_q, 0)), 32'h69);

        // Requesters 1 and 3 held.
        pulseReset();
        clearLogs();
        applyStimulus(4'b1010, {8'hBB, 8'h00, 8'hAA, 8'h00});
        waitGrants(3, 100);
        applyStimulus(4'b0000, 32'h0);
        tick(25);
        for (int i = 0; i < 3; i++)
            checkOutput("t6_order", 32'(at(gnt_id_q, i)), 32'(exp_t6[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one spi_master between NUM_REQ requesters, each sending one byte per transfer.
- Round-robin arbitration among requesters.
- For the granted requester: serialises the byte onto the master's cs_in/data_in inputs, then captures the master's parallel receive byte and returns it tagged with the requester id.
- Sits between the system-side clients and the spi_master/spi_slave pair in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, transfer width in bits
CLKS_PER_BIT, 2, clk cycles each serial bit is held on m_data_in (>=1)
GAP_CYCLES, 2, idle cycles with m_cs_in high between transfers (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester transfer request, held high until granted
req_data  input  NUM_REQ*DATA_W  per-requester tx byte, requester i at bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot, one-cycle pulse: request accepted and data latched
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: rx_data/rx_id valid
rx_data  output  DATA_W  byte captured from master
rx_id  output  3  index of requester that owned the completed transfer
m_cs_in  output  1  drives spi_master cs_in, active low
m_data_in  output  1  drives spi_master data_in, MSB first
m_dout  input  DATA_W  spi_master data_out

Behaviour:
- Reset (reset_n low at a clk edge): state=IDLE, m_cs_in=1, m_data_in=0, gnt=0, done=0, busy=0, rx_data=0, rx_id=0, rr pointer=0.
- Reset mid-transfer aborts it: m_cs_in high on that edge, no done.
- FSM states: IDLE, SHIFT, CAPTURE, GAP.
- IDLE:
  - If any req bit is set, choose the winner: first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Next edge: gnt[winner]=1 for one cycle, req_data slice latched into the shift register, rx_id latched, rr pointer=winner+1 (wrap to 0 after NUM_REQ-1), go to SHIFT.
- SHIFT:
  - m_cs_in=0 and m_data_in=shift[DATA_W-1], both registered, starting the same edge gnt rises.
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts left.
  - After DATA_W*CLKS_PER_BIT cycles: m_cs_in=1, go to CAPTURE.
- CAPTURE (1 cycle): on exiting, rx_data<=m_dout and done=1 for one cycle; go to GAP.
- GAP:
  - Hold m_cs_in=1, m_data_in=0 for GAP_CYCLES cycles; req is ignored.
  - Then go to IDLE.
- Latency: req seen in IDLE -> gnt next edge. m_cs_in low for exactly DATA_W*CLKS_PER_BIT cycles. done 1 cycle after m_cs_in rises. Next gnt no earlier than GAP_CYCLES+1 cycles after done.
- Boundaries:
  - req dropped before gnt: no transfer.
  - req held after gnt: treated as a new request on the next IDLE.
  - Single requester repeatedly requesting: back-to-back service, no starvation of others (rr).
  - All requesters asserted: served 0,1,2,3,0,... after reset.
  - rr pointer wraps NUM_REQ-1 -> 0.
  - gnt is never asserted outside IDLE->SHIFT.
  - gnt is one-hot or zero.
  - Counters are sized to cover DATA_W*CLKS_PER_BIT and GAP_CYCLES without overflow.

Optional Feature:
- Macro: SPI_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins; the rr pointer is not implemented.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset then req=4'b0100, req_data[2]=8'hA5, loopback master -> gnt=4'b0100 one cycle after req; m_data_in MSB first; m_cs_in low 16 cycles; done after 17 cycles; rx_id=2; rx_data equals master byte.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0; consecutive gnt pulses spaced 16+1+2+1=20 cycles.
- Only req[3] held continuously -> back-to-back transfers to 3; pointer wraps; then assert req[0] -> next grant 0 before 3.
- reset_n low 1 cycle during 5th bit of a transfer -> m_cs_in=1 next edge, no done; after release, req=4'b0011 grants 0 first.
- req[1] pulsed high for one cycle while busy -> no gnt[1] ever issued.
- SPI_ARB_FIXED_PRIO_EN defined, req=4'b1010 held -> gnt[1] every transfer; requester 3 never granted while req[1] stays high.
